// File: rtl/zone_backlight_extract_if.sv
// Stream bundle for zone_backlight_extract: the raster gray input, frame control,
// and the per-zone backlight output handshake toward the LED driver.
interface zone_backlight_extract_if #(
   parameter int IN_W       = 16,
   parameter int OUT_W      = 8,
   parameter int ZONE_IDX_W = 5
);
   logic                  frame_start;
   logic                  pix_valid;
   logic [IN_W-1:0]       gray_in;
   logic                  bl_valid;
   logic                  bl_ready;
   logic [OUT_W-1:0]      bl_data;
   logic [ZONE_IDX_W-1:0] bl_zone;
   logic                  frame_done;
   logic                  overflow;

   modport master (
      output frame_start, pix_valid, gray_in, bl_ready,
      input  bl_valid, bl_data, bl_zone, frame_done, overflow
   );

   modport slave (
      input  frame_start, pix_valid, gray_in, bl_ready,
      output bl_valid, bl_data, bl_zone, frame_done, overflow
   );
endinterface

// File: rtl/zone_backlight_extract.sv
// Tiles a raster gray stream into ZONES_X x ZONES_Y zones (power-of-two counts >= 2) and emits
// one backlight level per zone. Define ZBL_FLOOR_EN to clamp every level to at least MIN_BL.
module zone_backlight_extract #(
   parameter int ZONES_X     = 8,
   parameter int ZONES_Y     = 4,
   parameter int ZONE_W_LOG2 = 6,
   parameter int ZONE_H_LOG2 = 6,
   parameter int IN_W        = 16,
   parameter int OUT_W       = 8,
   parameter int MIN_BL      = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   zone_backlight_extract_if.slave bus
);
   localparam int W  = ZONES_X << ZONE_W_LOG2;
   localparam int H  = ZONES_Y << ZONE_H_LOG2;
   localparam int XW = $clog2(W);
   localparam int YW = $clog2(H);
   localparam int CW = $clog2(ZONES_X);
   localparam int RW = $clog2(ZONES_Y);
   localparam int ZW = $clog2(ZONES_X * ZONES_Y);
   localparam int SW = IN_W + ZONE_W_LOG2 + ZONE_H_LOG2;

`ifdef ZBL_FLOOR_EN
   localparam logic [OUT_W-1:0] MIN_BL_V = OUT_W'(MIN_BL);
`else
   logic unused_min_bl;
   assign unused_min_bl = (MIN_BL != 0);
`endif

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   state_t           state_q, state_d;
   logic [XW-1:0]    x_q, x_d;
   logic [YW-1:0]    y_q, y_d;
   logic [SW-1:0]    sum_q [ZONES_X];
   logic [SW-1:0]    sum_d [ZONES_X];
   logic [IN_W-1:0]  max_q [ZONES_X];
   logic [IN_W-1:0]  max_d [ZONES_X];
   logic [OUT_W-1:0] buf_q [ZONES_X];
   logic [OUT_W-1:0] buf_d [ZONES_X];
   logic [OUT_W-1:0] bl_new [ZONES_X];
   logic [CW-1:0]    rd_idx_q, rd_idx_d, rd_next;
   logic             bl_valid_q, bl_valid_d;
   logic [OUT_W-1:0] bl_data_q, bl_data_d;
   logic [ZW-1:0]    bl_zone_q, bl_zone_d;
   logic             frame_done_q, frame_done_d;
   logic             overflow_q, overflow_d;

   logic             pix_take, last_x, first_line, last_line, row_done, frame_end;
   logic             xfer, last_xfer;
   logic [CW-1:0]    col;
   logic [RW-1:0]    row;

   always_comb begin
      pix_take   = (state_q == S_ACTIVE) && bus.pix_valid && !bus.frame_start;
      col        = x_q[XW-1:ZONE_W_LOG2];
      row        = y_q[YW-1:ZONE_H_LOG2];
      last_x     = (x_q == XW'(W - 1));
      first_line = (y_q[ZONE_H_LOG2-1:0] == '0);
      last_line  = &y_q[ZONE_H_LOG2-1:0];
      row_done   = pix_take && last_x && last_line;
      frame_end  = row_done && (row == RW'(ZONES_Y - 1));
      xfer       = bl_valid_q && bus.bl_ready;
      last_xfer  = xfer && (rd_idx_q == CW'(ZONES_X - 1));
      rd_next    = rd_idx_q + CW'(1);
   end

   // Levels are derived from the post-update accumulators so the completing pixel is included.
   always_comb begin : acc_comb
      logic [IN_W-1:0]  mean;
      logic [IN_W:0]    bl_wide;
      logic [OUT_W-1:0] bl_sat;
      mean    = '0;
      bl_wide = '0;
      bl_sat  = '0;
      for (int c = 0; c < ZONES_X; c++) begin
         sum_d[c] = sum_q[c];
         max_d[c] = max_q[c];
         if (pix_take && col == CW'(c)) begin
            if (first_line && x_q[ZONE_W_LOG2-1:0] == '0) begin
               sum_d[c] = SW'(bus.gray_in);
               max_d[c] = bus.gray_in;
            end else begin
               sum_d[c] = sum_q[c] + SW'(bus.gray_in);
               if (bus.gray_in > max_q[c]) max_d[c] = bus.gray_in;
            end
         end
         mean    = sum_d[c][SW-1 -: IN_W];
         bl_wide = ({1'b0, max_d[c]} + {1'b0, mean}) >> 1;
         bl_sat  = (|bl_wide[IN_W:OUT_W]) ? '1 : bl_wide[OUT_W-1:0];
`ifdef ZBL_FLOOR_EN
         if (bl_sat < MIN_BL_V) bl_sat = MIN_BL_V;
`endif
         bl_new[c] = bl_sat;
      end
   end

   always_comb begin
      // NOTE: every signal gets its hold value first, so no path leaves it unassigned and no latch is inferred.
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      frame_done_d = 1'b0;
      if (bus.frame_start) begin
         state_d = S_ACTIVE;
         x_d     = '0;
         y_d     = '0;
      end else if (pix_take) begin
         if (last_x) begin
            x_d = '0;
            y_d = y_q + YW'(1);
            if (frame_end) begin
               y_d          = '0;
               state_d      = S_IDLE;
               frame_done_d = 1'b1;
            end
         end else begin
            x_d = x_q + XW'(1);
         end
      end
   end

   always_comb begin
      buf_d      = buf_q;
      rd_idx_d   = rd_idx_q;
      bl_valid_d = bl_valid_q;
      bl_data_d  = bl_data_q;
      bl_zone_d  = bl_zone_q;
      overflow_d = overflow_q;
      if (bus.frame_start) begin
         bl_valid_d = 1'b0;
         rd_idx_d   = '0;
         overflow_d = 1'b0;
      end else begin
         if (xfer) begin
            if (last_xfer) begin
               bl_valid_d = 1'b0;
            end else begin
               rd_idx_d  = rd_next;
               bl_data_d = buf_q[rd_next];
               bl_zone_d = bl_zone_q + ZW'(1);
            end
         end
         // A buffer emptied by this cycle's final transfer may take the new row.
         if (row_done) begin
            if (bl_valid_q && !last_xfer) begin
               overflow_d = 1'b1;
            end else begin
               buf_d      = bl_new;
               bl_valid_d = 1'b1;
               rd_idx_d   = '0;
               bl_data_d  = bl_new[0];
               bl_zone_d  = ZW'(row) * ZW'(ZONES_X);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state updates use <= so every flop samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q      <= S_IDLE;
         x_q          <= '0;
         y_q          <= '0;
         rd_idx_q     <= '0;
         bl_valid_q   <= 1'b0;
         bl_data_q    <= '0;
         bl_zone_q    <= '0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
         for (int c = 0; c < ZONES_X; c++) begin
            sum_q[c] <= '0;
            max_q[c] <= '0;
         end
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         rd_idx_q     <= rd_idx_d;
         bl_valid_q   <= bl_valid_d;
         bl_data_q    <= bl_data_d;
         bl_zone_q    <= bl_zone_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
         sum_q        <= sum_d;
         max_q        <= max_d;
      end
      // NOTE: the output buffer is only read behind bl_valid, so it carries no reset.
      buf_q <= buf_d;
   end

   assign bus.bl_valid   = bl_valid_q;
   assign bus.bl_data    = bl_data_q;
   assign bus.bl_zone    = bl_zone_q;
   assign bus.frame_done = frame_done_q;
   assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_zone_backlight_extract.sv
// Scoreboard bench for zone_backlight_extract on a reduced 64x16 frame (8x4 zones of 8x4 pixels).
`timescale 1ns/1ps
module tb_zone_backlight_extract;
   localparam int ZX     = 8;
   localparam int ZY     = 4;
   localparam int ZWL    = 3;
   localparam int ZHL    = 2;
   localparam int IN_W   = 16;
   localparam int OUT_W  = 8;
   localparam int MIN_BL = 16;
   localparam int ZPW    = 1 << ZWL;
   localparam int ZPH    = 1 << ZHL;
   localparam int W      = ZX * ZPW;
   localparam int H      = ZY * ZPH;
   localparam int ZIW    = $clog2(ZX * ZY);

   typedef enum int {K_UNI, K_SINGLE, K_RAND} kind_t;
   typedef struct {
      logic [ZIW-1:0]   zone;
      logic [OUT_W-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_xfer   = 0;
   int   n_done   = 0;
   int   uval     = 0;
   exp_t sb[$];

   zone_backlight_extract_if #(.IN_W(IN_W), .OUT_W(OUT_W), .ZONE_IDX_W(ZIW)) bus ();

   zone_backlight_extract #(
      .ZONES_X(ZX), .ZONES_Y(ZY), .ZONE_W_LOG2(ZWL), .ZONE_H_LOG2(ZHL),
      .IN_W(IN_W), .OUT_W(OUT_W), .MIN_BL(MIN_BL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic int pix_val(kind_t k, int x, int y);
      case (k)
         K_UNI:    return uval;
         K_SINGLE: return (x == 0 && y == 0) ? 510 : 0;
         default:  return (x * 37 + y * 101 + x * y * 13) & 255;
      endcase
   endfunction

   function automatic int exp_bl(kind_t k, int zr, int zc);
      int mx, s, v, bl;
      mx = 0;
      s  = 0;
      for (int yy = zr * ZPH; yy < (zr + 1) * ZPH; yy++) begin
         for (int xx = zc * ZPW; xx < (zc + 1) * ZPW; xx++) begin
            v = pix_val(k, xx, yy);
            s += v;
            if (v > mx) mx = v;
         end
      end
      bl = (mx + (s >> (ZWL + ZHL))) >> 1;
      if (bl > 255) bl = 255;
`ifdef ZBL_FLOOR_EN
      if (bl < MIN_BL) bl = MIN_BL;
`endif
      return bl;
   endfunction

   // Transfers complete at the next posedge; sample them at the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.bl_valid === 1'b1 && bus.bl_ready === 1'b1) begin
         n_xfer++;
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_xfer got zone=%0d data=%0d, expected no transfer", bus.bl_zone, bus.bl_data);
         end else begin
            e = sb.pop_front();
            if (bus.bl_zone !== e.zone || bus.bl_data !== e.data) begin
               n_fail++;
               $display("FAIL xfer got zone=%0d data=%0d, expected zone=%0d data=%0d",
                        bus.bl_zone, bus.bl_data, e.zone, e.data);
            end
         end
      end
      if (!rst && bus.frame_done === 1'b1) n_done++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_row(kind_t k, int zr);
      for (int zc = 0; zc < ZX; zc++)
         sb.push_back('{zone: ZIW'(zr * ZX + zc), data: OUT_W'(exp_bl(k, zr, zc))});
   endtask

   task automatic send_lines(kind_t k, int y0, int y1, bit drop);
      for (int y = y0; y <= y1; y++) begin
         for (int x = 0; x < W; x++) begin
            bus.pix_valid = 1'b1;
            bus.gray_in   = IN_W'(pix_val(k, x, y));
            if (x == W - 1 && (y % ZPH) == ZPH - 1 && !drop) push_row(k, y / ZPH);
            tick();
         end
      end
      bus.pix_valid = 1'b0;
   endtask

   task automatic start_frame();
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
   endtask

   task automatic wait_drained(string name);
      int cyc;
      cyc = 0;
      while ((sb.size() != 0 || bus.bl_valid !== 1'b0) && cyc < 400) begin
         tick();
         cyc++;
      end
      n_checks++;
      if (sb.size() != 0 || bus.bl_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_drain got pending=%0d bl_valid=%b, expected pending=0 bl_valid=0",
                  name, sb.size(), bus.bl_valid);
      end
   endtask

   task automatic check_outputs_zero(string name);
      n_checks++;
      if (bus.bl_valid !== 1'b0 || bus.bl_data !== '0 || bus.bl_zone !== '0 ||
          bus.frame_done !== 1'b0 || bus.overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL %s got valid=%b data=%0d zone=%0d done=%b ovf=%b, expected all 0", name,
                  bus.bl_valid, bus.bl_data, bus.bl_zone, bus.frame_done, bus.overflow);
      end
   endtask

   task automatic run_frame(kind_t k, string name);
      int d0, x0;
      d0 = n_done;
      x0 = n_xfer;
      bus.bl_ready = 1'b1;
      start_frame();
      send_lines(k, 0, H - 1, 1'b0);
      tick();
      wait_drained(name);
      n_checks++;
      if (n_done - d0 != 1) begin
         n_fail++;
         $display("FAIL %s_frame_done got pulses=%0d, expected 1", name, n_done - d0);
      end
      n_checks++;
      if (n_xfer - x0 != ZX * ZY) begin
         n_fail++;
         $display("FAIL %s_xfer_count got %0d, expected %0d", name, n_xfer - x0, ZX * ZY);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      check_outputs_zero("reset_state");
      rst = 1'b0;
      tick();
   endtask

   task automatic test_uniform();
      uval = 200;
      run_frame(K_UNI, "uniform200");
   endtask

   task automatic test_single_pixel();
      run_frame(K_SINGLE, "single_pixel");
   endtask

   task automatic test_saturate();
      uval = 510;
      run_frame(K_UNI, "all510");
      uval = 256;
      run_frame(K_UNI, "uniform256");
   endtask

   task automatic test_dark();
      uval = 0;
      run_frame(K_UNI, "dark");
   endtask

   task automatic test_random();
      run_frame(K_RAND, "pattern");
   endtask

   task automatic test_stall_overflow();
      int d0, x0;
      logic [OUT_W-1:0] hold_d;
      logic [ZIW-1:0]   hold_z;
      d0 = n_done;
      x0 = n_xfer;
      bus.bl_ready = 1'b0;
      start_frame();
      send_lines(K_RAND, 0, ZPH - 1, 1'b0);
      n_checks++;
      if (bus.bl_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL row_latency got bl_valid=%b, expected 1", bus.bl_valid);
      end
      bus.bl_ready = 1'b1;
      repeat (3) tick();
      bus.bl_ready = 1'b0;
      hold_d = bus.bl_data;
      hold_z = bus.bl_zone;
      n_checks++;
      if (hold_z !== ZIW'(3)) begin
         n_fail++;
         $display("FAIL stall_zone got %0d, expected 3", hold_z);
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         n_checks++;
         if (bus.bl_valid !== 1'b1 || bus.bl_data !== hold_d || bus.bl_zone !== hold_z) begin
            n_fail++;
            $display("FAIL stall_hold_%0d got valid=%b data=%0d zone=%0d, expected 1/%0d/%0d",
                     i, bus.bl_valid, bus.bl_data, bus.bl_zone, hold_d, hold_z);
         end
      end
      send_lines(K_RAND, ZPH, 2 * ZPH - 1, 1'b1);
      n_checks++;
      if (bus.overflow !== 1'b1 || bus.bl_zone !== hold_z || bus.bl_data !== hold_d) begin
         n_fail++;
         $display("FAIL overflow_set got ovf=%b zone=%0d data=%0d, expected 1/%0d/%0d",
                  bus.overflow, bus.bl_zone, bus.bl_data, hold_z, hold_d);
      end
      bus.bl_ready = 1'b1;
      send_lines(K_RAND, 2 * ZPH, H - 1, 1'b0);
      tick();
      wait_drained("stall");
      n_checks++;
      if (n_xfer - x0 != ZX * (ZY - 1)) begin
         n_fail++;
         $display("FAIL stall_xfer_count got %0d, expected %0d", n_xfer - x0, ZX * (ZY - 1));
      end
      n_checks++;
      if (n_done - d0 != 1 || bus.overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_end got done=%0d ovf=%b, expected 1/1", n_done - d0, bus.overflow);
      end
   endtask

   task automatic test_abort();
      int d0, x0;
      bus.bl_ready = 1'b0;
      start_frame();
      send_lines(K_RAND, 0, ZPH - 1, 1'b0);
      send_lines(K_RAND, ZPH, 2 * ZPH - 1, 1'b1);
      send_lines(K_RAND, 2 * ZPH, 2 * ZPH + 1, 1'b0);
      n_checks++;
      if (bus.bl_valid !== 1'b1 || bus.overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_pre got valid=%b ovf=%b, expected 1/1", bus.bl_valid, bus.overflow);
      end
      sb.delete();
      bus.frame_start = 1'b1;
      bus.pix_valid   = 1'b1;
      bus.gray_in     = IN_W'(4000);
      tick();
      bus.frame_start = 1'b0;
      bus.pix_valid   = 1'b0;
      n_checks++;
      if (bus.bl_valid !== 1'b0 || bus.overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_flush got valid=%b ovf=%b, expected 0/0", bus.bl_valid, bus.overflow);
      end
      d0 = n_done;
      x0 = n_xfer;
      bus.bl_ready = 1'b1;
      uval = 50;
      send_lines(K_UNI, 0, H - 1, 1'b0);
      tick();
      wait_drained("abort_gray50");
      n_checks++;
      if (n_done - d0 != 1 || n_xfer - x0 != ZX * ZY) begin
         n_fail++;
         $display("FAIL abort_frame got done=%0d xfers=%0d, expected 1/%0d", n_done - d0, n_xfer - x0, ZX * ZY);
      end
   endtask

   task automatic test_rst_mid_drain();
      int d0, x0;
      bus.bl_ready = 1'b0;
      start_frame();
      send_lines(K_RAND, 0, ZPH - 1, 1'b0);
      send_lines(K_RAND, ZPH, 2 * ZPH - 1, 1'b1);
      sb.delete();
      rst = 1'b1;
      tick();
      check_outputs_zero("rst_mid_drain");
      rst = 1'b0;
      d0 = n_done;
      x0 = n_xfer;
      bus.bl_ready = 1'b1;
      for (int i = 0; i < W * H + 4; i++) begin
         bus.pix_valid = 1'b1;
         bus.gray_in   = IN_W'(300);
         tick();
      end
      bus.pix_valid = 1'b0;
      tick();
      n_checks++;
      if (bus.bl_valid !== 1'b0 || n_xfer != x0 || n_done != d0) begin
         n_fail++;
         $display("FAIL idle_ignore got valid=%b xfers=%0d done=%0d, expected 0/0/0",
                  bus.bl_valid, n_xfer - x0, n_done - d0);
      end
      run_frame(K_RAND, "after_rst");
   endtask

   initial begin
      bus.frame_start = 1'b0;
      bus.pix_valid   = 1'b0;
      bus.gray_in     = '0;
      bus.bl_ready    = 1'b0;
      test_reset();
      test_uniform();
      test_single_pixel();
      test_saturate();
      test_dark();
      test_random();
      test_stall_overflow();
      test_abort();
      test_rst_mid_drain();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
